// File: rtl/bus_store_scheduler.sv
// ============================================================================
// Module   : bus_store_scheduler
// Purpose  : Transaction-level arbiter for the shared AXI write channel.
//            Two write masters (m0 = data-cache store path, m1 = uncached /
//            writeback path) compete for a single slave write port. The
//            winner owns AW, W and B from address issue until its write
//            response completes, so bursts from the two masters never
//            interleave.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            m{0,1}_aw*            - per-master write address channel
//            m{0,1}_w*             - per-master write data channel
//            m{0,1}_b*             - per-master write response channel
//            s_aw*, s_w*, s_b*     - single slave-side write port
//            owner                 - current / last granted master
//            busy                  - high whenever a transaction is active
// Config   : BUS_STORE_RR_EN       - when defined, simultaneous requests are
//                                    granted round-robin; otherwise m0 has
//                                    fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_store_scheduler #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    // master 0
    input  logic                m0_awvalid,
    output logic                m0_awready,
    input  logic [ADDR_W-1:0]   m0_awaddr,
    input  logic [7:0]          m0_awlen,
    input  logic [2:0]          m0_awsize,
    input  logic                m0_wvalid,
    output logic                m0_wready,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    input  logic                m0_wlast,
    output logic                m0_bvalid,
    input  logic                m0_bready,
    output logic [1:0]          m0_bresp,
    // master 1
    input  logic                m1_awvalid,
    output logic                m1_awready,
    input  logic [ADDR_W-1:0]   m1_awaddr,
    input  logic [7:0]          m1_awlen,
    input  logic [2:0]          m1_awsize,
    input  logic                m1_wvalid,
    output logic                m1_wready,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    input  logic                m1_wlast,
    output logic                m1_bvalid,
    input  logic                m1_bready,
    output logic [1:0]          m1_bresp,
    // slave port
    output logic                s_awvalid,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [7:0]          s_awlen,
    output logic [2:0]          s_awsize,
    input  logic                s_awready,
    output logic                s_wvalid,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    input  logic                s_wready,
    input  logic                s_bvalid,
    input  logic [1:0]          s_bresp,
    output logic                s_bready,
    // status
    output logic                owner,
    output logic                busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_AW   = 2'd1;
    localparam logic [1:0] S_W    = 2'd2;
    localparam logic [1:0] S_B    = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_owner;
    logic       w_grant;
    logic       w_req_any;

    // Owner-selected handshake inputs, used by both next-state and output logic
    logic       w_own_awvalid;
    logic       w_own_wvalid;
    logic       w_own_wlast;
    logic       w_own_bready;

    assign w_req_any     = m0_awvalid | m1_awvalid;
    assign w_own_awvalid = r_owner ? m1_awvalid : m0_awvalid;
    assign w_own_wvalid  = r_owner ? m1_wvalid  : m0_wvalid;
    assign w_own_wlast   = r_owner ? m1_wlast   : m0_wlast;
    assign w_own_bready  = r_owner ? m1_bready  : m0_bready;

`ifdef BUS_STORE_RR_EN
    // Remembers who won the last grant; reset to 1 so m0 wins the first tie.
    logic r_last_grant;

    always_comb begin
        if (m0_awvalid && m1_awvalid) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = m1_awvalid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if ((r_state == S_IDLE) && w_req_any) begin
            r_last_grant <= w_grant;
        end
    end
`else
    // Fixed priority: m1 is granted only when m0 is not asking.
    assign w_grant = m1_awvalid & ~m0_awvalid;
`endif

    // ------------------------------------------------------------------
    // State register (owner is latched only on the IDLE->AW edge)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && w_req_any) begin
                r_owner <= w_grant;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_req_any)                               w_state_nxt = S_AW;
            S_AW:   if (w_own_awvalid && s_awready)              w_state_nxt = S_W;
            S_W:    if (w_own_wvalid && s_wready && w_own_wlast) w_state_nxt = S_B;
            S_B:    if (s_bvalid && w_own_bready)                w_state_nxt = S_IDLE;
            default:                                             w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: payloads follow the owner unconditionally, only the
    // valid/ready/bvalid strobes are qualified by state and ownership.
    // ------------------------------------------------------------------
    always_comb begin
        s_awaddr   = r_owner ? m1_awaddr : m0_awaddr;
        s_awlen    = r_owner ? m1_awlen  : m0_awlen;
        s_awsize   = r_owner ? m1_awsize : m0_awsize;
        s_wdata    = r_owner ? m1_wdata  : m0_wdata;
        s_wstrb    = r_owner ? m1_wstrb  : m0_wstrb;
        s_wlast    = r_owner ? m1_wlast  : m0_wlast;
        m0_bresp   = s_bresp;
        m1_bresp   = s_bresp;

        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        m0_awready = 1'b0;
        m1_awready = 1'b0;
        m0_wready  = 1'b0;
        m1_wready  = 1'b0;
        m0_bvalid  = 1'b0;
        m1_bvalid  = 1'b0;

        case (r_state)
            S_AW: begin
                s_awvalid  = w_own_awvalid;
                m0_awready = ~r_owner & s_awready;
                m1_awready =  r_owner & s_awready;
            end
            S_W: begin
                s_wvalid   = w_own_wvalid;
                m0_wready  = ~r_owner & s_wready;
                m1_wready  =  r_owner & s_wready;
            end
            S_B: begin
                s_bready   = w_own_bready;
                m0_bvalid  = ~r_owner & s_bvalid;
                m1_bvalid  =  r_owner & s_bvalid;
            end
            default: begin
            end
        endcase
    end

    assign owner = r_owner;
    assign busy  = (r_state != S_IDLE);

endmodule

`default_nettype wire
